unison_readout_rx: RTL and testbench
====================================

UNISON_READOUT_RX -- requirements
Module: unison_readout_rx

Interface
REQ-001 The block SHALL have parameter WORD_BITS, default 16: bits per lane per frame; must be even, range 4..32.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4: frame-word FIFO entries; must be a power of 2, range 2..16.
REQ-003 The block SHALL have port wb_clk_i, input, width 1: the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port wb_rst_i, input, width 1: reset, asynchronous and active-high.
REQ-005 The block SHALL have port clk_master, input, width 1: the bit clock driving the digital_unison core; asynchronous to wb_clk_i.
REQ-006 The block SHALL have port read_out_I, input, width 2: I-lane serial pair, launched by the core per clk_master cycle.
REQ-007 The block SHALL have port read_out_Q, input, width 2: Q-lane serial pair, launched by the core per clk_master cycle.
REQ-008 The block SHALL have port rx_en, input, width 1: capture enable, synchronous to wb_clk_i.
REQ-009 The block SHALL have port clr_ovf, input, width 1: one-cycle pulse that clears the overflow flag.
REQ-010 The block SHALL have port out_data, output, width 2*WORD_BITS: the frame word, {I_word, Q_word}.
REQ-011 The block SHALL have ports out_valid (output, width 1) and out_ready (input, width 1): the output handshake.
REQ-012 The block SHALL have port overflow, output, width 1: sticky flag, set when a frame is dropped.
REQ-013 The block SHALL have port busy, output, width 1: high while in state CAPTURE.

Function
REQ-014 clk_master, read_out_I and read_out_Q SHALL each pass through a 2-flop synchronizer to wb_clk_i.
REQ-015 A sample strobe SHALL assert for one cycle when the synchronized clk_master is 1 and its previous registered value is 0.
REQ-016 The strobe SHALL capture the synchronized lane bits that are in the same pipeline stage as the detected clk_master edge.
REQ-017 The FSM SHALL have 2 states, IDLE and CAPTURE; the reset state SHALL be IDLE.
REQ-018 In IDLE with rx_en=1, the FSM SHALL enter CAPTURE on the next cycle, with the bit counter at 0 and both shift registers at 0.
REQ-019 In CAPTURE, each strobe SHALL apply I_sh <= {I_sh, read_out_I[1], read_out_I[0]}, do the same for Q, and increment the counter; first-received bits land MSB-first.
REQ-020 On the strobe that makes counter = WORD_BITS/2, the block SHALL push {I_sh_next, Q_sh_next} into the FIFO on that same edge and reset the counter to 0.
REQ-021 After a push, the block SHALL remain in CAPTURE; frames SHALL be back-to-back with no gap samples.
REQ-022 If rx_en=0 in CAPTURE, the block SHALL go to IDLE next cycle and discard the partial frame; a strobe in that same cycle SHALL NOT push.
REQ-023 out_valid SHALL equal FIFO-not-empty, registered, and SHALL rise the cycle after the first push into an empty FIFO.
REQ-024 out_data SHALL present the head entry while out_valid=1 and SHALL hold its last value while out_valid=0.
REQ-025 A pop SHALL occur when out_valid & out_ready; the next entry, if any, SHALL be presented the following cycle.
REQ-026 Push when full without a pop SHALL drop the new frame, leave the FIFO unchanged and set overflow=1.
REQ-027 Push and pop in the same cycle when full SHALL both succeed, with no overflow.
REQ-028 Push and pop in the same cycle when the FIFO holds 1 entry SHALL leave count=1, out_valid=1, and present the new word.
REQ-029 overflow SHALL clear on clr_ovf=1; if a drop occurs in the same cycle, set SHALL win.
REQ-030 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer bit or a count.

Reset
REQ-031 While wb_rst_i=1, the block SHALL hold: state=IDLE, counter=0, shift registers=0, synchronizers=0, FIFO pointers=0, out_valid=0, out_data=0, overflow=0, busy=0.
REQ-032 Asserting wb_rst_i mid-frame or with the FIFO non-empty SHALL discard all data immediately, without waiting for a clock edge.
REQ-033 After reset release, the first strobe SHALL be taken only from a 0-to-1 transition of the synchronized clk_master.

Verification
REQ-034 Bench scenario, single frame: WORD_BITS=16, rx_en=1, 8 clk_master cycles with I=2'b10 and Q=2'b01 -> exactly one word out_data=0xAAAA5555, out_valid=1.
REQ-035 Bench scenario, ordering: I pairs 3,0,0,0,0,0,0,1 -> I_word=0xC001.
REQ-036 Bench scenario, overflow: out_ready=0 for 5 frames with FIFO_DEPTH=4 -> 4 words held, overflow=1 after frame 5, then pops return frames 1..4 in order.
REQ-037 Bench scenario, full with pop: FIFO full and out_ready=1 on the push cycle -> no overflow, and count stays 4.
REQ-038 Bench scenario, abort: rx_en dropped after 5 samples then re-raised -> the next frame holds only post-restart data, and no partial word is pushed.
REQ-039 Bench scenario, reset during capture: wb_rst_i pulsed at sample 3 of frame 2 -> all outputs are 0 asynchronously, and capture resumes cleanly.

Source files
------------

// File: rtl/unison_readout_rx.sv
// Receiver for the digital_unison I/Q serial readout: it synchronizes the bit clock and
// the lanes, assembles {I_word, Q_word} frames and buffers them in a small FIFO.
module unison_readout_rx #(
    parameter int WORD_BITS  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   clk_master,
    input  logic [1:0]             read_out_I,
    input  logic [1:0]             read_out_Q,
    input  logic                   rx_en,
    input  logic                   clr_ovf,
    output logic [2*WORD_BITS-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   overflow,
    output logic                   busy
);

    localparam int HALF  = WORD_BITS / 2;
    localparam int CNT_W = $clog2(HALF + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PW    = AW + 1;
    localparam int DW    = 2 * WORD_BITS;

    typedef enum logic {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    logic             r_cm_s1, r_cm_s2, r_cm_prev;
    logic [1:0]       r_i_s1, r_i_s2, r_q_s1, r_q_s2;
    logic             w_strobe;

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [WORD_BITS-1:0] r_i_sh, r_q_sh, w_i_sh_next, w_q_sh_next;
    logic             w_push;
    logic [DW-1:0]    w_push_data;

    logic [DW-1:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0]    r_wr_ptr, r_rd_ptr, w_wr_next, w_rd_next, w_count;
    logic [AW-1:0]    w_rd_next_idx;
    logic             w_full, w_pop, w_push_ok, w_drop, w_valid_next;
    logic [DW-1:0]    w_head, w_out_data_next;
    logic             r_out_valid, r_overflow;
    logic [DW-1:0]    r_out_data;

    // Lanes ride through the same two stages as clk_master so the strobe sees aligned bits.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_cm_s1   <= 1'b0;
            r_cm_s2   <= 1'b0;
            r_cm_prev <= 1'b0;
            r_i_s1    <= '0;
            r_i_s2    <= '0;
            r_q_s1    <= '0;
            r_q_s2    <= '0;
        end else begin
            r_cm_s1   <= clk_master;
            r_cm_s2   <= r_cm_s1;
            r_cm_prev <= r_cm_s2;
            r_i_s1    <= read_out_I;
            r_i_s2    <= r_i_s1;
            r_q_s1    <= read_out_Q;
            r_q_s2    <= r_q_s1;
        end
    end

    assign w_strobe = r_cm_s2 & ~r_cm_prev;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_i_sh_next  = r_i_sh;
        w_q_sh_next  = r_q_sh;
        w_push       = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_next  = '0;
                w_i_sh_next = '0;
                w_q_sh_next = '0;
                if (rx_en) begin
                    w_state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!rx_en) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                    w_i_sh_next  = '0;
                    w_q_sh_next  = '0;
                end else if (w_strobe) begin
                    w_i_sh_next = {r_i_sh[WORD_BITS-3:0], r_i_s2};
                    w_q_sh_next = {r_q_sh[WORD_BITS-3:0], r_q_s2};
                    if (r_cnt == CNT_W'(HALF - 1)) begin
                        w_push     = 1'b1;
                        w_cnt_next = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_cnt  <= '0;
            r_i_sh <= '0;
            r_q_sh <= '0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_i_sh <= w_i_sh_next;
            r_q_sh <= w_q_sh_next;
        end
    end

    assign w_push_data = {w_i_sh_next, w_q_sh_next};

    // A full FIFO still accepts a push when the head leaves on the same edge.
    always_comb begin
        w_count       = r_wr_ptr - r_rd_ptr;
        w_full        = (w_count == PW'(FIFO_DEPTH));
        w_pop         = r_out_valid & out_ready;
        w_push_ok     = w_push & (~w_full | w_pop);
        w_drop        = w_push & ~w_push_ok;
        w_wr_next     = r_wr_ptr + {{AW{1'b0}}, w_push_ok};
        w_rd_next     = r_rd_ptr + {{AW{1'b0}}, w_pop};
        w_rd_next_idx = w_rd_next[AW-1:0];
        w_valid_next  = (w_wr_next != w_rd_next);
        // The word being written becomes the head when the FIFO drains to it this edge.
        if (w_push_ok && (r_wr_ptr[AW-1:0] == w_rd_next_idx)) begin
            w_head = w_push_data;
        end else begin
            w_head = r_mem[w_rd_next_idx];
        end
        w_out_data_next = w_valid_next ? w_head : r_out_data;
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_push_data;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_next;
            r_rd_ptr    <= w_rd_next;
            r_out_valid <= w_valid_next;
            r_out_data  <= w_out_data_next;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign overflow  = r_overflow;
    assign busy      = (r_state == CAPTURE);

endmodule

// File: tb/tb_unison_readout_rx.sv
// Scoreboard bench for unison_readout_rx: a frame-level model predicts each word and
// drop, and a monitor pops predictions whenever the DUT hands a word over.
module tb_unison_readout_rx;

    localparam int WB    = 16;
    localparam int DEPTH = 4;
    localparam int HALF  = WB / 2;

    logic          wb_clk_i   = 1'b0;
    logic          wb_rst_i   = 1'b1;
    logic          clk_master = 1'b0;
    logic [1:0]    read_out_I = '0;
    logic [1:0]    read_out_Q = '0;
    logic          rx_en      = 1'b0;
    logic          clr_ovf    = 1'b0;
    logic          out_ready  = 1'b0;
    logic [2*WB-1:0] out_data;
    logic          out_valid;
    logic          overflow;
    logic          busy;

    unison_readout_rx #(
        .WORD_BITS (WB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .clk_master(clk_master),
        .read_out_I(read_out_I),
        .read_out_Q(read_out_Q),
        .rx_en     (rx_en),
        .clr_ovf   (clr_ovf),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [2*WB-1:0] exp_q[$];
    logic [1:0]    cur_i[$];
    logic [1:0]    cur_q[$];
    bit            exp_ovf    = 1'b0;
    bit            rand_ready = 1'b0;
    logic [2*WB-1:0] last_exp = '0;
    logic [1:0]    fi[HALF];
    logic [1:0]    fq[HALF];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Frame word: the k-th received pair occupies bits [W-1-2k : W-2-2k].
    task automatic model_sample(input logic [1:0] si, input logic [1:0] sq, input bit rdy);
        logic [WB-1:0] wi;
        logic [WB-1:0] wq;
        cur_i.push_back(si);
        cur_q.push_back(sq);
        if (cur_i.size() == HALF) begin
            wi = '0;
            wq = '0;
            for (int k = 0; k < HALF; k++) begin
                wi = wi + (WB'(cur_i[k]) << (WB - 2 - 2 * k));
                wq = wq + (WB'(cur_q[k]) << (WB - 2 - 2 * k));
            end
            cur_i.delete();
            cur_q.delete();
            if (exp_q.size() >= DEPTH && !rdy) exp_ovf = 1'b1;
            else exp_q.push_back({wi, wq});
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge wb_clk_i);
            #2;
        end
    endtask

    // One clk_master period; optionally raise out_ready so a pop lands on the capture edge.
    task automatic send_sample(input logic [1:0] si, input logic [1:0] sq, input bit rdy);
        int unsigned n1;
        int unsigned n2;
        n1 = $urandom_range(2, 4);
        n2 = $urandom_range(3, 5);
        read_out_I = si;
        read_out_Q = sq;
        clk_master = 1'b0;
        cycles(int'(n1));
        clk_master = 1'b1;
        model_sample(si, sq, rdy);
        for (int k = 0; k < int'(n2); k++) begin
            @(posedge wb_clk_i);
            #2;
            if (k == 1 && rdy) out_ready = 1'b1;
        end
    endtask

    task automatic send_frame(input bit rdy_last);
        for (int k = 0; k < HALF; k++) send_sample(fi[k], fq[k], rdy_last && (k == HALF - 1));
    endtask

    task automatic fill_rand();
        for (int k = 0; k < HALF; k++) begin
            fi[k] = 2'($urandom_range(0, 3));
            fq[k] = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 400; c++) begin
            if (exp_q.size() == 0) break;
            cycles(1);
        end
        check(name, 64'(exp_q.size()), 64'd0);
        cycles(2);
    endtask

    always @(negedge wb_clk_i) begin
        if (!wb_rst_i && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_word: got %h, required no word", out_data);
            end else begin
                last_exp = exp_q.pop_front();
                if (out_data !== last_exp) begin
                    n_err++;
                    $display("FAIL word: got %h, required %h", out_data, last_exp);
                end
            end
        end
    end

    always begin
        @(posedge wb_clk_i);
        #2;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run not complete, required completion before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cycles(3);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        wb_rst_i = 1'b0;
        cycles(3);
        check("idle_busy", 64'(busy), 64'd0);

        rx_en = 1'b1;
        cycles(2);
        check("capture_busy", 64'(busy), 64'd1);
        for (int k = 0; k < HALF; k++) begin
            fi[k] = 2'b10;
            fq[k] = 2'b01;
        end
        send_frame(1'b0);
        cycles(2);
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_data", 64'(out_data), 64'hAAAA5555);
        out_ready = 1'b1;
        wait_drain("single_drain");
        check("single_empty", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        fill_rand();
        fi[0] = 2'd3;
        for (int k = 1; k < HALF - 1; k++) fi[k] = 2'd0;
        fi[HALF-1] = 2'd1;
        send_frame(1'b0);
        cycles(2);
        check("order_iword", 64'(out_data[2*WB-1:WB]), 64'hC001);
        out_ready = 1'b1;
        wait_drain("order_drain");

        fill_rand();
        for (int k = 0; k < 5; k++) send_sample(fi[k], fq[k], 1'b0);
        rx_en = 1'b0;
        cycles(3);
        check("abort_busy", 64'(busy), 64'd0);
        cur_i.delete();
        cur_q.delete();
        rx_en = 1'b1;
        cycles(2);
        fill_rand();
        send_frame(1'b0);
        wait_drain("abort_drain");
        check("abort_empty", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        repeat (5) begin
            fill_rand();
            send_frame(1'b0);
        end
        cycles(2);
        check("ovf_set", 64'(overflow), 64'(exp_ovf));
        check("ovf_valid", 64'(out_valid), 64'd1);
        clr_ovf = 1'b1;
        cycles(1);
        clr_ovf = 1'b0;
        exp_ovf = 1'b0;
        cycles(1);
        check("ovf_clear", 64'(overflow), 64'(exp_ovf));
        out_ready = 1'b1;
        wait_drain("ovf_drain");

        out_ready = 1'b0;
        repeat (4) begin
            fill_rand();
            send_frame(1'b0);
        end
        fill_rand();
        send_frame(1'b1);
        cycles(2);
        check("fullpop_ovf", 64'(overflow), 64'(exp_ovf));
        wait_drain("fullpop_drain");

        rand_ready = 1'b1;
        repeat (6) begin
            fill_rand();
            send_frame(1'b0);
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        wait_drain("rand_drain");
        check("rand_ovf", 64'(overflow), 64'(exp_ovf));

        out_ready = 1'b0;
        fill_rand();
        send_frame(1'b0);
        fill_rand();
        for (int k = 0; k < 3; k++) send_sample(fi[k], fq[k], 1'b0);
        cycles(1);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        check("pre_rst_busy", 64'(busy), 64'd1);
        @(posedge wb_clk_i);
        #3;
        wb_rst_i   = 1'b1;
        clk_master = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_data", 64'(out_data), 64'd0);
        check("arst_ovf", 64'(overflow), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        cur_i.delete();
        cur_q.delete();
        exp_ovf = 1'b0;
        cycles(2);
        wb_rst_i = 1'b0;
        cycles(2);
        check("post_rst_busy", 64'(busy), 64'd1);
        out_ready = 1'b1;
        fill_rand();
        send_frame(1'b0);
        wait_drain("post_rst_drain");

        cycles(3);
        check("final_valid", 64'(out_valid), 64'd0);
        check("final_hold", 64'(out_data), 64'(last_exp));
        check("final_ovf", 64'(overflow), 64'(exp_ovf));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
